// File: rtl/piso_shift_register.sv
// rtl/piso_shift_register.sv - parallel-in serial-out shift register with valid/ready word input
module piso_shift_register #(
   parameter int DATA_WIDTH = 16,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  din_valid,
   output logic                  din_ready,
   output logic                  dout,
   output logic                  dout_valid,
   output logic                  dout_last
);

   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [DATA_WIDTH-1:0] shreg;
   logic [DATA_WIDTH-1:0] shreg_next;
   logic [DATA_WIDTH-1:0] shreg_shifted;
   logic [CW-1:0]         cnt;
   logic [CW-1:0]         cnt_next;
   logic                  at_last;
   logic                  accept;
   logic                  out_bit;

   // Outputs come from registered state only; reset forces every output low.
   assign at_last    = (state == SHIFT) && (cnt == LAST_CNT);
   assign dout_valid = !reset && (state == SHIFT);
   assign dout_last  = !reset && at_last;
   // Ready on the last bit lets the next word follow with no bubble.
   assign din_ready  = !reset && ((state == IDLE) || at_last);
   assign accept     = din_valid && din_ready;
   assign out_bit    = MSB_FIRST ? shreg[DATA_WIDTH-1] : shreg[0];
   assign dout       = dout_valid && out_bit;

   // Move the next bit toward the output end, zero-filling behind it.
   assign shreg_shifted = MSB_FIRST ? {shreg[DATA_WIDTH-2:0], 1'b0}
                                    : {1'b0, shreg[DATA_WIDTH-1:1]};

   // State, shift register and bit counter update.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
      end else begin
         state <= state_next;
         shreg <= shreg_next;
         cnt   <= cnt_next;
      end
   end

   // Next-state: load on accept, shift mid-word, decide reload or idle on the last bit.
   always_comb begin
      state_next = state;
      shreg_next = shreg;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = SHIFT;
               shreg_next = din;
               cnt_next   = '0;
            end
         end
         SHIFT: begin
            if (!at_last) begin
               shreg_next = shreg_shifted;
               cnt_next   = cnt + CW'(1);
            end else if (accept) begin
               shreg_next = din;
               cnt_next   = '0;
            end else begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

endmodule
